// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//
// Frames the byte stream coming out of the UART receiver into
//   HDR, CMD, LEN, LEN payload bytes, CSUM
// and publishes each good frame to the control logic.
//
// CSUM is the mod-256 sum of CMD, LEN and the payload bytes. HDR is not
// included in the sum.
//
// The payload memory has two banks. One bank is the committed bank, which
// rd_addr/rd_data read. The other bank is the staging bank, which a frame in
// progress writes. A good checksum swaps the roles of the two banks. This
// means the reader always sees a complete, checked payload.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   rx_done_tick one-cycle strobe; din is valid in the same cycle
//   din          received byte
//   rd_addr      payload read address into the committed bank
//   rd_data      combinational read of the committed bank at rd_addr
//   frame_valid  one-cycle pulse: a new frame has been committed
//   frame_cmd    command byte of the last committed frame
//   frame_len    payload length of the last committed frame
//   err_csum     one-cycle pulse: checksum mismatch, frame dropped
//   err_len      one-cycle pulse: LEN > MAX_LEN, frame dropped
//   err_timeout  one-cycle pulse: inter-byte timeout, frame dropped
//   busy         high while a frame is in progress (state != IDLE)
//
// Handshake: the receiver side has no back-pressure. Every cycle in which
// rx_done_tick is high delivers exactly one byte on din, and that byte is
// consumed in that same cycle. Only these cycles (and the timeout) move the
// FSM.

module uart_frame_parser #(
    parameter logic [7:0] HDR     = 8'hA5,
    parameter int         MAX_LEN = 8,
    parameter int         AW      = 3,
    parameter int         TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_done_tick,
    input  logic [7:0]    din,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_valid,
    output logic [7:0]    frame_cmd,
    output logic [AW:0]   frame_len,
    output logic          err_csum,
    output logic          err_len,
    output logic          err_timeout,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;
    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Frame working registers
    logic [7:0]    cmd_tmp;
    logic [AW:0]   len_tmp;
    logic [7:0]    sum;
    logic [AW-1:0] idx;
    logic [TW-1:0] tcnt;

    // Two payload banks. bank_sel names the committed bank, so the staging
    // bank is always the other one.
    logic [7:0]    bank0 [DEPTH];
    logic [7:0]    bank1 [DEPTH];
    logic          bank_sel;

    // Decision terms shared by the next-state and output logic
    logic len_bad;
    logic last_data;
    logic csum_ok;
    logic timeout_hit;

    // Outputs of the FSM output logic, registered below
    logic commit;
    logic csum_fail;
    logic len_fail;
    logic stage_we;

    assign len_bad   = (din > 8'(MAX_LEN));
    assign last_data = ({1'b0, idx} == (len_tmp - (AW+1)'(1)));
    assign csum_ok   = (din == sum);

    // A byte that arrives in the expiry cycle wins over the timeout.
    assign timeout_hit = (state != S_IDLE) && !rx_done_tick &&
                         (tcnt == TW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = S_IDLE;
        end else if (rx_done_tick) begin
            case (state)
                S_IDLE: if (din == HDR) state_next = S_CMD;
                S_CMD:  state_next = S_LEN;
                S_LEN: begin
                    if (len_bad)          state_next = S_IDLE;
                    else if (din == 8'h00) state_next = S_CSUM;
                    else                   state_next = S_DATA;
                end
                S_DATA: if (last_data) state_next = S_CSUM;
                S_CSUM: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        commit    = 1'b0;
        csum_fail = 1'b0;
        len_fail  = 1'b0;
        stage_we  = 1'b0;
        if (rx_done_tick) begin
            case (state)
                S_LEN:  len_fail = len_bad;
                S_DATA: stage_we = 1'b1;
                S_CSUM: begin
                    commit    = csum_ok;
                    csum_fail = !csum_ok;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Datapath: working registers, timeout counter, registered pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_tmp     <= 8'h00;
            len_tmp     <= '0;
            sum         <= 8'h00;
            idx         <= '0;
            tcnt        <= '0;
            bank_sel    <= 1'b0;
            frame_cmd   <= 8'h00;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            frame_valid <= commit;
            err_csum    <= csum_fail;
            err_len     <= len_fail;
            err_timeout <= timeout_hit;

            // The counter measures the gap since the last byte of a frame.
            // It rests at zero while idle.
            if (state == S_IDLE || rx_done_tick || timeout_hit) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end

            if (rx_done_tick) begin
                case (state)
                    S_CMD: begin
                        cmd_tmp <= din;
                        sum     <= din;
                    end
                    S_LEN: begin
                        if (!len_bad) begin
                            // din <= MAX_LEN <= 2**AW here, so the slice is lossless
                            len_tmp <= din[AW:0];
                            sum     <= sum + din;
                            idx     <= '0;
                        end
                    end
                    S_DATA: begin
                        sum <= sum + din;
                        if (!last_data) idx <= idx + AW'(1);
                    end
                    default: ;
                endcase
            end

            if (commit) begin
                bank_sel  <= ~bank_sel;
                frame_cmd <= cmd_tmp;
                frame_len <= len_tmp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload banks. Writes only ever target the staging bank.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank0[i] <= 8'h00;
                bank1[i] <= 8'h00;
            end
        end else if (stage_we) begin
            if (bank_sel) bank0[idx] <= din;
            else          bank1[idx] <= din;
        end
    end

    assign rd_data = bank_sel ? bank1[rd_addr] : bank0[rd_addr];

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//
// Self-checking bench for uart_frame_parser, built with TIMEOUT = 20.
//
// A frame-level reference model follows the byte stream using a queue of
// the bytes received since HDR, plus a count of silent cycles. Every cycle,
// all outputs are compared against this model. Committed frames are also
// queued and matched against each frame_valid pulse. Directed scenarios
// then spot-check known constants.

module tb_uart_frame_parser;

    localparam logic [7:0] HDR     = 8'hA5;
    localparam int         MAX_LEN = 8;
    localparam int         AW      = 3;
    localparam int         TIMEOUT = 20;
    localparam int         DEPTH   = 1 << AW;

    logic          clk;
    logic          reset;
    logic          rx_done_tick;
    logic [7:0]    din;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_valid;
    logic [7:0]    frame_cmd;
    logic [AW:0]   frame_len;
    logic          err_csum;
    logic          err_len;
    logic          err_timeout;
    logic          busy;

    uart_frame_parser #(
        .HDR(HDR), .MAX_LEN(MAX_LEN), .AW(AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
        .frame_cmd(frame_cmd), .frame_len(frame_len), .err_csum(err_csum),
        .err_len(err_len), .err_timeout(err_timeout), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_q[$];          // {cmd, len} of expected commits
    logic [7:0]  tx_q[$];           // bytes for the driver

    bit          m_in_frame;
    logic [7:0]  m_fq[$];           // bytes after HDR of the current frame
    int          m_gap;
    logic [7:0]  m_bank[2][DEPTH];
    int          m_sel;
    logic [7:0]  m_cmd;
    int          m_len;
    bit          m_valid, m_ecsum, m_elen, m_eto;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_in_frame = 0;
        m_fq.delete();
        m_gap = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) m_bank[b][i] = 8'h00;
        m_sel = 0; m_cmd = 8'h00; m_len = 0;
        m_valid = 0; m_ecsum = 0; m_elen = 0; m_eto = 0;
        exp_q.delete();
    endtask

    task automatic model_update(input bit tick, input logic [7:0] b);
        int n, len, s;
        m_valid = 0; m_ecsum = 0; m_elen = 0; m_eto = 0;
        if (m_in_frame) begin
            if (tick) begin
                m_gap = 0;
                m_fq.push_back(b);
                n = m_fq.size();
                if (n == 2) begin
                    if (int'(b) > MAX_LEN) begin
                        m_elen = 1;
                        m_in_frame = 0;
                    end
                end else if (n >= 3) begin
                    len = int'(m_fq[1]);
                    if (n <= len + 2) begin
                        m_bank[1 - m_sel][n - 3] = b;
                    end else begin
                        s = 0;
                        for (int i = 0; i < n - 1; i++) s += int'(m_fq[i]);
                        if ((s % 256) == int'(b)) begin
                            m_valid = 1;
                            m_sel   = 1 - m_sel;
                            m_cmd   = m_fq[0];
                            m_len   = len;
                            exp_q.push_back({m_cmd, 4'(m_len)});
                        end else begin
                            m_ecsum = 1;
                        end
                        m_in_frame = 0;
                    end
                end
            end else begin
                m_gap++;
                if (m_gap >= TIMEOUT) begin
                    m_eto = 1;
                    m_in_frame = 0;
                end
            end
        end else if (tick && b == HDR) begin
            m_in_frame = 1;
            m_fq.delete();
            m_gap = 0;
        end
    endtask

    task automatic compare_all();
        logic [11:0] e;
        check("frame_valid", frame_valid, m_valid);
        check("err_csum", err_csum, m_ecsum);
        check("err_len", err_len, m_elen);
        check("err_timeout", err_timeout, m_eto);
        check("busy", busy, m_in_frame);
        check("frame_cmd", frame_cmd, m_cmd);
        check("frame_len", frame_len, m_len);
        check("rd_data", rd_data, m_bank[m_sel][rd_addr]);
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("frame_sb", {frame_cmd, frame_len}, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Each step starts and ends at a falling edge.
    task automatic step(input bit tick, input logic [7:0] b);
        rx_done_tick = tick;
        din          = b;
        rd_addr      = AW'($urandom_range(0, DEPTH - 1));
        @(posedge clk);
        model_update(tick, b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic send_q(input int max_gap);
        while (tx_q.size() > 0) begin
            idle($urandom_range(0, max_gap));
            step(1'b1, tx_q.pop_front());
        end
        rx_done_tick = 1'b0;
    endtask

    task automatic check_rd(input string tag, input int addr, input logic [7:0] exp);
        rd_addr = AW'(addr);
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_done_tick = 1'b0;
        #1;
        model_reset();
        check("rst_valid", frame_valid, 0);
        check("rst_cmd", frame_cmd, 0);
        check("rst_len", frame_len, 0);
        check("rst_errs", {err_csum, err_len, err_timeout}, 0);
        check("rst_busy", busy, 0);
        check_rd("rst_rd0", 0, 8'h00);
        check_rd("rst_rd1", 1, 8'h00);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_to;
        bit busy_at_to;
        bit saw_to;
        int len, s, cut;
        logic [7:0] g, c;

        reset = 1'b1; rx_done_tick = 1'b0; din = 8'h00; rd_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Scenario 1: valid frame
        tx_q = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89};
        send_q(0);
        check("s1_valid", frame_valid, 1);
        check("s1_cmd", frame_cmd, 8'h10);
        check("s1_len", frame_len, 2);
        check("s1_noerr", {err_csum, err_len, err_timeout}, 0);
        check_rd("s1_rd0", 0, 8'h33);
        check_rd("s1_rd1", 1, 8'h44);
        idle(2);

        // Scenario 3: bad checksum leaves the committed frame alone
        tx_q = '{8'hA5, 8'h11, 8'h01, 8'h55, 8'h00};
        send_q(1);
        check("s3_csum", err_csum, 1);
        check("s3_novalid", frame_valid, 0);
        check("s3_cmd", frame_cmd, 8'h10);
        check_rd("s3_rd0", 0, 8'h33);
        idle(2);

        // Scenario 2: zero-length frame
        tx_q = '{8'hA5, 8'h20, 8'h00, 8'h20};
        send_q(1);
        check("s2_valid", frame_valid, 1);
        check("s2_cmd", frame_cmd, 8'h20);
        check("s2_len", frame_len, 0);
        idle(1);
        check("s2_busy", busy, 0);

        // Scenario 4: garbage, over-length, then a good frame
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h09};
        send_q(2);
        check("s4_errlen", err_len, 1);
        tx_q = '{8'hA5, 8'h30, 8'h01, 8'h7F, 8'hB0};
        send_q(0);
        check("s4_valid", frame_valid, 1);
        check("s4_cmd", frame_cmd, 8'h30);
        check_rd("s4_rd0", 0, 8'h7F);
        idle(2);

        // Scenario 5a: silence after CMD times out 20 cycles later
        tx_q = '{8'hA5, 8'h10};
        send_q(0);
        first_to = -1;
        busy_at_to = 1'b1;
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            step(1'b0, 8'h00);
            if (err_timeout && first_to < 0) begin
                first_to = k;
                busy_at_to = busy;
            end
        end
        check("s5_to_delay", first_to, TIMEOUT);
        check("s5_busy_fall", busy_at_to, 0);

        // Scenario 5b: a byte in the expiry cycle wins
        tx_q = '{8'hA5, 8'h10};
        send_q(0);
        saw_to = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            step(1'b0, 8'h00);
            if (err_timeout) saw_to = 1'b1;
        end
        tx_q = '{8'h02, 8'h33, 8'h44, 8'h89};
        send_q(0);
        if (err_timeout) saw_to = 1'b1;
        check("s5b_no_to", saw_to, 0);
        check("s5b_valid", frame_valid, 1);
        idle(2);

        // Scenario 6: reset mid-frame, then a frame lands in bank 1
        tx_q = '{8'hA5, 8'h10, 8'h02, 8'h33};
        send_q(0);
        @(negedge clk);
        do_reset();
        tx_q = '{8'hA5, 8'h40, 8'h03, 8'h01, 8'h02, 8'h03, 8'h49};
        send_q(1);
        check("s6_valid", frame_valid, 1);
        check("s6_cmd", frame_cmd, 8'h40);
        check("s6_bank", dut.bank_sel, 1);
        check_rd("s6_rd2", 2, 8'h03);
        check_rd("s6_rd3", 3, 8'h00);
        idle(2);

        // Randomized frames: garbage, over-length, bad sums, truncations
        for (int f = 0; f < 60; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                g = 8'($urandom);
                if (g == HDR) g = 8'h00;
                tx_q.push_back(g);
            end
            c = 8'($urandom);
            len = $urandom_range(0, MAX_LEN + 2);
            tx_q.push_back(HDR);
            tx_q.push_back(c);
            tx_q.push_back(8'(len));
            if (len <= MAX_LEN) begin
                s = int'(c) + len;
                for (int j = 0; j < len; j++) begin
                    g = 8'($urandom);
                    s += int'(g);
                    tx_q.push_back(g);
                end
                if ($urandom_range(0, 3) == 0) s += 1;
                tx_q.push_back(8'(s));
                if ($urandom_range(0, 9) == 0) begin
                    cut = $urandom_range(1, len + 2);
                    repeat (cut) void'(tx_q.pop_back());
                end
            end
            send_q(3);
            if ($urandom_range(0, 7) == 0) idle(TIMEOUT + 2);
        end
        idle(TIMEOUT + 2);
        check("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
